chip8_keypad_scanner: RTL and testbench
=======================================

# chip8_keypad_scanner

- Drives and scans a physical 4x4 hex keypad matrix for the CHIP-8 core and debounces every key.
- Presents the debounced state as a 16-bit vector that feeds the CPU's `keyboard[15:0]` input directly.
- Also emits press/release events in the same 8-bit `keyval` format the current keyboard path uses.
- Sits directly upstream of `chip8_cpu` and replaces the DPI `get_key` source in synthesizable builds.

## Interface
Parameters:
- `SCAN_DIV`, 1000: clocks each column is driven; legal minimum 8.
- `DEBOUNCE`, 4: consecutive disagreeing scans required to flip a key's state; legal range 1..15.
- `EVT_DEPTH`, 4: event FIFO entries; must be a power of two, at least 2.

Ports:
- `clk_in`, in, 1: system clock.
- `rst_n_in`, in, 1: reset; asynchronous assert, active-low.
- `row_n_in`, in, 4: matrix rows; pulled up externally, low means pressed; asynchronous to `clk_in`.
- `col_n_out`, out, 4: column drive; one-cold.
- `keys_out`, out, 16: debounced state; bit k is 1 while hex key k is held.
- `evt_valid_out`, out, 1: event FIFO not empty.
- `evt_data_out`, out, 8: head event. Bit 7 is 1 for press, 0 for release. Bits 6:4 are 0. Bits 3:0 are the key code.
- `evt_ready_in`, in, 1: consumer accepts the head event.
- `evt_overflow_out`, out, 1: sticky; set when an event is dropped.

## Operation
Column drive:
- Columns are driven 0,1,2,3,0,… with each column held for `SCAN_DIV` clocks. A dwell counter wraps at `SCAN_DIV-1`.

Row sampling:
- `row_n_in` passes through a 2-flop synchronizer.
- At dwell count `SCAN_DIV-1`, the synchronized rows are inverted and captured into a sample latch. The column index is captured with them.

Row processing:
- Processing happens at dwell counts 0..3 of the next column, one row r per cycle.
- Key code k is `KEYMAP[row][col]`, using the standard layout: `1 2 3 C` / `4 5 6 D` / `7 8 9 E` / `A 0 B F`, row 0 at the top, column 0 at the left.

Debounce, per key:
- Each key has a 4-bit counter `cnt[k]`.
- If the sample equals `keys_out[k]`, `cnt[k]` is set to 0.
- Otherwise `cnt[k]` increments.
- When the incremented value reaches `DEBOUNCE`, `keys_out[k]` toggles, `cnt[k]` is set to 0, and an event `{new_state, 3'b000, k}` is pushed.

Event FIFO:
- At most one push per cycle (guaranteed by the per-row processing order).
- A pop occurs when `evt_valid_out && evt_ready_in`.
- Push onto a full FIFO:
  - The new event is dropped and `evt_overflow_out` is set.
  - `keys_out` still updates.
- Push and pop in the same cycle on a full FIFO: both succeed and nothing is dropped.
- Pointers wrap modulo `EVT_DEPTH` and carry an extra bit to distinguish full from empty.
- `evt_data_out` is undefined when the FIFO is empty. The bench checks it only while valid.

Simultaneous presses:
- Multiple keys in one column flipping in the same scan produce events in ascending row order.
- Ghost keys from the matrix are not filtered.

## Timing
Reset values:
- `col_n_out` = 4'b1111, with no column driven until the first clock after release.
- `keys_out` = 0, `evt_valid_out` = 0, `evt_overflow_out` = 0.
- All `cnt` = 0, dwell counter = 0, column = 0, sample latch = 0.
- The first cycle after reset drives column 0.

Reset mid-operation:
- Clears everything immediately, including queued events and overflow. No release events are generated.

Scan period and latency:
- Full scan period: `4*SCAN_DIV` clocks.
- Press-to-`keys_out` latency: `DEBOUNCE` scans plus at most 2 sync cycles, 1 dwell, and 4 processing cycles.
- The event becomes visible on `evt_valid_out` one clock after the `keys_out` update.

Handshake:
- `evt_data_out` stays stable while `evt_valid_out` is high and not yet accepted.
- `evt_ready_in` may be held permanently high.

Changing `row_n_in` during processing has no effect; the sample latch is frozen.

## Configuration
- `KEYPAD_EVENT_EN` defined: the event FIFO and overflow logic are present, as described above.
- Not defined: the FIFO and overflow logic are removed. `evt_valid_out` = 0, `evt_data_out` = 8'hFF, and `evt_overflow_out` = 0, all constant. `evt_ready_in` is ignored. `keys_out` behaviour is unchanged.

## Structure
- Package `chip8_pkg` holds:
  - the `KEYMAP` 4x4 array of 4-bit codes;
  - the `keyval_t` 8-bit typedef;
  - the constant `KEYVAL_NONE` = 8'hFF;
  - the constant `KEY_PRESS_BIT` = 7.
- Sub-module `chip8_evt_fifo` is a generic synchronous FIFO parameterized on width and depth. It is instantiated only under `KEYPAD_EVENT_EN`.

## Test plan
Benches use `SCAN_DIV=8` and `DEBOUNCE=2` unless stated otherwise.
- **Reset:** assert `rst_n_in` low mid-scan. Outputs immediately show `col_n_out`=1111, `keys_out`=0, `evt_valid_out`=0. After release, `col_n_out` steps 1110→1101→1011→0111, 8 clocks each.
- **Single press:** hold row 1 low whenever column 2 is driven. After 2 scans, `keys_out`=16'h0040 (key 6). Event 8'h86 is popped. On release, 8'h06 follows after 2 scans.
- **Bounce:** key 0 (row 3, column 1) is present for 1 scan, absent for 1 scan, then present for 2 scans. Exactly one press event 8'h80 occurs, after the final two scans.
- **Multi-key:** keys 1, 4 and 7 (column 0, rows 0, 1, 2) are pressed in the same scan. Events arrive in the order 8'h81, 8'h84, 8'h87. `keys_out`=16'h0092.
- **Overflow:** with `EVT_DEPTH=4` and `evt_ready_in`=0, press 5 keys. The FIFO holds the first 4 events and `evt_overflow_out`=1. `keys_out` reflects all 5 keys. The overflow flag stays set after draining the FIFO.
- **Config off:** build without `KEYPAD_EVENT_EN` and repeat the single-press test. `keys_out` is identical to the enabled build. `evt_valid_out`=0 and `evt_data_out`=8'hFF throughout.

Source files
------------

// File: rtl/chip8_pkg.sv
// chip8_pkg: shared keypad constants and the 8-bit keyval event format.
package chip8_pkg;

  typedef logic [7:0] keyval_t;

  localparam keyval_t     KEYVAL_NONE   = 8'hFF;
  localparam int unsigned KEY_PRESS_BIT = 7;

  // Hex code at [row][col]; row 0 is the top, column 0 the left.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'h0, 4'hB, 4'hF}
  };

  // Builds {pressed, 3'b000, code}.
  function automatic keyval_t make_keyval(input logic pressed, input logic [3:0] code);
    keyval_t kv;
    kv                = '0;
    kv[KEY_PRESS_BIT] = pressed;
    kv[3:0]           = code;
    return kv;
  endfunction

endpackage

// File: rtl/chip8_evt_fifo.sv
// chip8_evt_fifo: generic synchronous FIFO with extra-bit pointers.
// Only compiled when KEYPAD_EVENT_EN is defined, the sole configuration that uses it.
`ifdef KEYPAD_EVENT_EN
module chip8_evt_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  input  logic [Width-1:0] wr_data_i,
  output logic             wr_ready_o,
  output logic             rd_valid_o,
  output logic [Width-1:0] rd_data_o,
  input  logic             rd_ready_i
);
  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && rd_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_ready_o = !full || pop;
  assign push       = wr_valid_i && wr_ready_o;

  assign rd_valid_o = !empty;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule
`endif

// File: rtl/chip8_keypad_scanner.sv
// chip8_keypad_scanner: scans and debounces a 4x4 hex keypad for the CHIP-8 core.
// Define KEYPAD_EVENT_EN to include the press/release event FIFO and overflow flag.
module chip8_keypad_scanner
  import chip8_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned EVT_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [3:0]  row_n_in,
  output logic [3:0]  col_n_out,
  output logic [15:0] keys_out,
  output logic        evt_valid_out,
  output logic [7:0]  evt_data_out,
  input  logic        evt_ready_in,
  output logic        evt_overflow_out
);
  localparam int unsigned DW        = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DwLast  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DwRows  = DW'(4);

  logic             active_q;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       row_meta_q, row_sync_q;
  logic [3:0]       sample_q;
  logic [1:0]       sample_col_q;
  logic [15:0]      keys_q, keys_d;
  logic [15:0][3:0] cnt_q, cnt_d;
  logic             push_d;
  keyval_t          push_data_d;

  logic [1:0]       proc_row;
  logic [3:0]       proc_code;
  logic             proc_smp, proc_en;
  logic [3:0]       cnt_inc;

  // Scan timing: dwell counter and column index advance once the scanner is running.
  always_comb begin
    dwell_d = dwell_q;
    col_d   = col_q;
    if (active_q) begin
      if (dwell_q == DwLast) begin
        dwell_d = '0;
        col_d   = col_q + 2'd1;
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  // Scan state, row synchronizer and the sample latch frozen at end of dwell.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_q     <= 1'b0;
      dwell_q      <= '0;
      col_q        <= '0;
      row_meta_q   <= 4'hF;
      row_sync_q   <= 4'hF;
      sample_q     <= '0;
      sample_col_q <= '0;
    end else begin
      active_q   <= 1'b1;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      row_meta_q <= row_n_in;
      row_sync_q <= row_meta_q;
      if (active_q && (dwell_q == DwLast)) begin
        sample_q     <= ~row_sync_q;
        sample_col_q <= col_q;
      end
    end
  end

  assign col_n_out = active_q ? ~(4'b0001 << col_q) : 4'b1111;

  // One row of the latched column is debounced per cycle in dwell slots 0..3.
  assign proc_row  = dwell_q[1:0];
  assign proc_code = KEYMAP[proc_row][sample_col_q];
  assign proc_smp  = sample_q[proc_row];
  assign proc_en   = active_q && (dwell_q < DwRows);
  assign cnt_inc   = cnt_q[proc_code] + 4'd1;

  // Per-key debounce next-state and event generation.
  always_comb begin
    keys_d      = keys_q;
    cnt_d       = cnt_q;
    push_d      = 1'b0;
    push_data_d = make_keyval(proc_smp, proc_code);
    if (proc_en) begin
      if (proc_smp == keys_q[proc_code]) begin
        cnt_d[proc_code] = '0;
      end else if (cnt_inc == 4'(DEBOUNCE)) begin
        keys_d[proc_code] = proc_smp;
        cnt_d[proc_code]  = '0;
        push_d            = 1'b1;
      end else begin
        cnt_d[proc_code] = cnt_inc;
      end
    end
  end

  // Debounced key state and counters.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      keys_q <= '0;
      cnt_q  <= '0;
    end else begin
      keys_q <= keys_d;
      cnt_q  <= cnt_d;
    end
  end

  assign keys_out = keys_q;

`ifdef KEYPAD_EVENT_EN
  logic    push_q;
  keyval_t push_data_q;
  logic    fifo_wr_ready;
  logic    overflow_q;

  // Events are staged one cycle so they appear the clock after keys_out changes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      push_q      <= push_d;
      push_data_q <= push_data_d;
      if (push_q && !fifo_wr_ready) overflow_q <= 1'b1;
    end
  end

  chip8_evt_fifo #(
    .Width (8),
    .Depth (EVT_DEPTH)
  ) u_evt_fifo (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .wr_valid_i (push_q),
    .wr_data_i  (push_data_q),
    .wr_ready_o (fifo_wr_ready),
    .rd_valid_o (evt_valid_out),
    .rd_data_o  (evt_data_out),
    .rd_ready_i (evt_ready_in)
  );

  assign evt_overflow_out = overflow_q;
`else
  logic unused_evt;
  assign unused_evt       = ^{evt_ready_in, push_d, push_data_d, EVT_DEPTH[0]};
  assign evt_valid_out    = 1'b0;
  assign evt_data_out     = KEYVAL_NONE;
  assign evt_overflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// tb_chip8_keypad_scanner: scoreboard bench for the keypad scanner (either build).
module tb_chip8_keypad_scanner;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned DEBOUNCE  = 2;
  localparam int unsigned EVT_DEPTH = 4;
  localparam int unsigned SCAN      = 4 * SCAN_DIV;

  localparam logic [3:0] TB_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'h0, 4'hB, 4'hF}
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keys;
  logic        evt_valid;
  logic [7:0]  evt_data;
  logic        evt_ready = 1'b1;
  logic        evt_ovf;
  logic [15:0] pressed = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_keys[$];
  logic [7:0]  exp_evt[$];
  logic [15:0] prev_keys = '0;
`ifdef KEYPAD_EVENT_EN
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        stable_bad = 1'b0;
`else
  logic        const_bad = 1'b0;
`endif

  always #5 clk = ~clk;

  chip8_keypad_scanner #(
    .SCAN_DIV  (SCAN_DIV),
    .DEBOUNCE  (DEBOUNCE),
    .EVT_DEPTH (EVT_DEPTH)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .row_n_in         (row_n),
    .col_n_out        (col_n),
    .keys_out         (keys),
    .evt_valid_out    (evt_valid),
    .evt_data_out     (evt_data),
    .evt_ready_in     (evt_ready),
    .evt_overflow_out (evt_ovf)
  );

  // Keypad matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col_n[c] && pressed[TB_MAP[r][c]]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_key(input logic [15:0] k);
    exp_keys.push_back(k);
  endtask

  task automatic expect_evt(input logic [7:0] e);
    exp_evt.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Every queued expectation must have been consumed by now.
  task automatic end_phase(input string tag);
    check({tag, "_keys_left"}, 16'(exp_keys.size()), 16'd0);
`ifdef KEYPAD_EVENT_EN
    check({tag, "_evts_left"}, 16'(exp_evt.size()), 16'd0);
`else
    exp_evt.delete();
`endif
  endtask

  // Align to the first cycle of column 0.
  task automatic to_scan_start();
    int guard = 0;
    @(negedge clk);
    while (col_n != 4'b0111 && guard < 200) begin @(negedge clk); guard++; end
    while (col_n != 4'b1110 && guard < 200) begin @(negedge clk); guard++; end
    check("scan_align", {15'd0, guard < 200}, 16'd1);
    #1;
  endtask

  task automatic check_col_steps(input string tag);
    logic [3:0] one;
    logic [3:0] exp_col;
    one = 4'b0001;
    for (int i = 0; i < int'(SCAN); i++) begin
      @(negedge clk);
      exp_col = ~(one << (i / int'(SCAN_DIV)));
      check(tag, {12'd0, col_n}, {12'd0, exp_col});
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, {12'd0, col_n}, 16'h000F);
    check({tag, "_keys"}, keys, 16'h0000);
    check({tag, "_valid"}, {15'd0, evt_valid}, 16'd0);
    check({tag, "_ovf"}, {15'd0, evt_ovf}, 16'd0);
  endtask

  // keys_out monitor: every change must match the next queued expectation.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_keys = keys;
    end else if (keys !== prev_keys) begin
      check("keys_change_expected", {15'd0, exp_keys.size() != 0}, 16'd1);
      if (exp_keys.size() != 0) check("keys_change", keys, exp_keys.pop_front());
      prev_keys = keys;
    end
  end

  // Event monitor: accepted events are compared against the queue.
  initial forever begin
    @(negedge clk);
`ifdef KEYPAD_EVENT_EN
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && evt_data !== prev_data) stable_bad = 1'b1;
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        check("evt_expected", {15'd0, exp_evt.size() != 0}, 16'd1);
        if (exp_evt.size() != 0) check("evt_data", {8'd0, evt_data}, {8'd0, exp_evt.pop_front()});
      end
      prev_hold = (evt_valid === 1'b1) && !evt_ready;
      prev_data = evt_data;
    end
`else
    if (evt_valid !== 1'b0 || evt_data !== 8'hFF || evt_ovf !== 1'b0) const_bad = 1'b1;
`endif
  end

  initial begin
    // Power-on reset and column stepping.
    wait_cycles(3);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    check_col_steps("col_step0");

    // Single press of key 6 (row 1, column 2) and its release.
    to_scan_start();
    pressed[6] = 1'b1;
    expect_key(16'h0040);
    expect_evt(8'h86);
    wait_cycles(SCAN + 4);
    check("press6_early", keys, 16'h0000);
    wait_cycles(3 * SCAN);
    check("press6_keys", keys, 16'h0040);
    end_phase("press6");
    to_scan_start();
    pressed[6] = 1'b0;
    expect_key(16'h0000);
    expect_evt(8'h06);
    wait_cycles(4 * SCAN);
    check("rel6_keys", keys, 16'h0000);
    end_phase("rel6");

    // Bounce on key 0 (row 3, column 1): 1 scan on, 1 off, then held.
    to_scan_start();
    pressed[0] = 1'b1;
    wait_cycles(SCAN);
    pressed[0] = 1'b0;
    wait_cycles(SCAN);
    check("bounce_hold", keys, 16'h0000);
    pressed[0] = 1'b1;
    expect_key(16'h0001);
    expect_evt(8'h80);
    wait_cycles(4 * SCAN);
    check("bounce_keys", keys, 16'h0001);
    end_phase("bounce");
    to_scan_start();
    pressed[0] = 1'b0;
    expect_key(16'h0000);
    expect_evt(8'h00);
    wait_cycles(4 * SCAN);
    end_phase("bounce_rel");

    // Keys 1, 4, 7 in column 0 in the same scan: ascending row order.
    to_scan_start();
    pressed = 16'h0092;
    expect_key(16'h0002); expect_key(16'h0012); expect_key(16'h0092);
    expect_evt(8'h81);    expect_evt(8'h84);    expect_evt(8'h87);
    wait_cycles(4 * SCAN);
    check("multi_keys", keys, 16'h0092);
    end_phase("multi");
    to_scan_start();
    pressed = 16'h0000;
    expect_key(16'h0090); expect_key(16'h0080); expect_key(16'h0000);
    expect_evt(8'h01);    expect_evt(8'h04);    expect_evt(8'h07);
    wait_cycles(4 * SCAN);
    end_phase("multi_rel");

    // Overflow: five presses with the consumer stalled.
    evt_ready = 1'b0;
    to_scan_start();
    pressed = 16'h0496;
    expect_key(16'h0002); expect_key(16'h0012); expect_key(16'h0092);
    expect_key(16'h0492); expect_key(16'h0496);
    expect_evt(8'h81); expect_evt(8'h84); expect_evt(8'h87); expect_evt(8'h8A);
    wait_cycles(4 * SCAN);
    check("ovf_keys", keys, 16'h0496);
`ifdef KEYPAD_EVENT_EN
    check("ovf_flag", {15'd0, evt_ovf}, 16'd1);
    check("ovf_valid", {15'd0, evt_valid}, 16'd1);
    check("ovf_head", {8'd0, evt_data}, 16'h0081);
`else
    check("off_ovf_flag", {15'd0, evt_ovf}, 16'd0);
    check("off_valid", {15'd0, evt_valid}, 16'd0);
    check("off_data", {8'd0, evt_data}, 16'h00FF);
`endif
    evt_ready = 1'b1;
    wait_cycles(10);
    end_phase("ovf_drain");
`ifdef KEYPAD_EVENT_EN
    check("ovf_sticky", {15'd0, evt_ovf}, 16'd1);
    check("ovf_drained", {15'd0, evt_valid}, 16'd0);
`endif

    // Reset mid-scan with keys held and overflow set.
    to_scan_start();
    wait_cycles(5);
    rst_n = 1'b0;
    pressed = 16'h0000;
    #1;
    check_reset_outputs("rst_mid");
    wait_cycles(2);
    check_reset_outputs("rst_mid_hold");
    rst_n = 1'b1;
    check_col_steps("col_step1");
    wait_cycles(2 * SCAN);
    end_phase("post_rst");

`ifdef KEYPAD_EVENT_EN
    check("evt_stable", {15'd0, stable_bad}, 16'd0);
`else
    check("evt_const", {15'd0, const_bad}, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
